// File: rtl/finite_diff_pkg.sv
// Shared constants, FSM state type and saturating-add helper for the
// finite-difference gradient blocks.
package finite_diff_pkg;

  localparam int WIDTH        = 32;
  localparam int FRAC         = 16;
  localparam int NPIX         = 4096;
  localparam int CNT_W        = 12;
  localparam int ACC_W        = 48;
  localparam int DRAIN_CYCLES = 2;
  localparam int SAT_W        = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Unsigned add clamped to 2^w-1; operands are zero-extended into SAT_W bits.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int               w);
    logic [SAT_W:0]   s;
    logic [SAT_W-1:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
    return (s > {1'b0, lim}) ? lim : s[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/sq_mag_pipe.sv
// Two-stage squared-magnitude datapath: register dx^2 and dy^2, then sum,
// drop the fractional bits and saturate to WIDTH bits.
module sq_mag_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_dx,
  input  logic signed [WIDTH-1:0] i_dy,
  output logic                    o_valid,
  output logic        [WIDTH-1:0] o_mag
);

  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0] sqX_q;
  logic signed [PW-1:0] sqY_q;
  logic                 valid1_q;
  logic        [PW:0]   sumWide;
  logic        [PW:0]   shifted;
  logic   [WIDTH-1:0]   mag_d;

  // Operands are sign-extended to the full product width first, so the
  // most negative input squares to +2^(2*WIDTH-2) without wrapping.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid1_q <= 1'b0;
      sqX_q    <= '0;
      sqY_q    <= '0;
    end else begin
      valid1_q <= i_valid;
      if (i_valid) begin
        sqX_q <= PW'(i_dx) * PW'(i_dx);
        sqY_q <= PW'(i_dy) * PW'(i_dy);
      end
    end
  end

  always_comb begin
    sumWide = {1'b0, sqX_q} + {1'b0, sqY_q};
    shifted = sumWide >> FRAC;
    mag_d   = (|shifted[PW:WIDTH]) ? '1 : shifted[WIDTH-1:0];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_mag   <= '0;
    end else begin
      o_valid <= valid1_q;
      if (valid1_q) begin
        o_mag <= mag_d;
      end
    end
  end

endmodule

// File: rtl/grad_mag_acc.sv
// Squared gradient magnitude stream plus saturating per-frame energy sum
// with a one-cycle done pulse once the pipeline has drained.
module grad_mag_acc #(
  parameter int WIDTH = finite_diff_pkg::WIDTH,
  parameter int FRAC  = finite_diff_pkg::FRAC,
  parameter int NPIX  = finite_diff_pkg::NPIX,
  parameter int CNT_W = finite_diff_pkg::CNT_W,
  parameter int ACC_W = finite_diff_pkg::ACC_W
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_dx,
  input  logic signed [WIDTH-1:0] i_dy,
  output logic                    o_valid,
  output logic        [WIDTH-1:0] o_mag,
  output logic        [ACC_W-1:0] o_sum,
  output logic                    o_done,
  output logic                    o_busy
);

  import finite_diff_pkg::*;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       drainCnt_q;
  logic             done_q;
  logic             busy_q;
  logic [ACC_W-1:0] sum_q;
  logic [ACC_W-1:0] sum_d;
  logic             accept;

  assign accept = (state_q == RUN) && i_valid;

  sq_mag_pipe #(
    .WIDTH(WIDTH),
    .FRAC (FRAC)
  ) u_pipe (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_valid(accept),
    .i_dx   (i_dx),
    .i_dy   (i_dy),
    .o_valid(o_valid),
    .o_mag  (o_mag)
  );

  // DRAIN holds until the last sample has been folded into the sum, so the
  // done pulse and the falling busy line both land after o_sum is final.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      drainCnt_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (i_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(NPIX - 1)) begin
              state_q    <= DRAIN;
              drainCnt_q <= '0;
            end
          end
        end
        DRAIN: begin
          drainCnt_q <= drainCnt_q + 1'b1;
          if (drainCnt_q == 2'(DRAIN_CYCLES)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    sum_d = ACC_W'(sat_add(SAT_W'(sum_q), SAT_W'(o_mag), ACC_W));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sum_q <= '0;
    end else if ((state_q == IDLE) && i_start) begin
      sum_q <= '0;
    end else if (o_valid) begin
      sum_q <= sum_d;
    end
  end

  assign o_sum  = sum_q;
  assign o_done = done_q;
  assign o_busy = busy_q;

endmodule
